// File: rtl/big_alu_pkg.sv
// Shared constants for the big_alu sign-magnitude adder/subtractor.
package big_alu_pkg;

  localparam int   DATA_WIDTH_DEFAULT = 24;
  localparam int   CLA_GROUP          = 4;
  localparam logic OP_ADD             = 1'b0;
  localparam logic OP_SUB             = 1'b1;

endpackage

// File: rtl/big_alu_cla_adder.sv
// Carry-lookahead adder: 4-bit groups with group generate/propagate and lookahead across groups.
module big_alu_cla_adder
  import big_alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GS = CLA_GROUP;
  localparam int NG = (WIDTH + GS - 1) / GS;
  localparam int WP = NG * GS;

  logic [WP-1:0] xp;
  logic [WP-1:0] yp;
  logic [WP-1:0] p;
  logic [WP-1:0] g;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG-1:0] gc;
  logic [WP:0]   c;

  assign xp = WP'(x);
  assign yp = WP'(y);
  assign p  = xp ^ yp;
  assign g  = xp & yp;

  always_comb begin
    logic gen_acc;
    logic prop_acc;
    gg = '0;
    gp = '0;
    for (int k = 0; k < NG; k++) begin
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int i = 0; i < GS; i++) begin
        gen_acc  = g[k*GS+i] | (p[k*GS+i] & gen_acc);
        prop_acc = prop_acc & p[k*GS+i];
      end
      gg[k] = gen_acc;
      gp[k] = prop_acc;
    end
  end

  // Each group carry-in is a flat function of lower group G/P and cin.
  always_comb begin
    logic acc;
    gc = '0;
    for (int k = 0; k < NG; k++) begin
      acc = cin;
      for (int j = 0; j < k; j++) begin
        acc = gg[j] | (gp[j] & acc);
      end
      gc[k] = acc;
    end
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*GS] = gc[k];
      for (int i = 0; i < GS; i++) begin
        c[k*GS+i+1] = g[k*GS+i] | (p[k*GS+i] & c[k*GS+i]);
      end
    end
  end

  assign sum  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/big_alu.sv
// Sign-magnitude add/subtract with one output register stage.
// Define BIG_ALU_CLA_EN to build the magnitude datapath from big_alu_cla_adder.
module big_alu
  import big_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sign_a,
  input  logic                  sign_b,
  input  logic                  symbol,
  output logic [DATA_WIDTH:0]   out,
  output logic                  sign_out,
  output logic                  out_valid
);

  localparam int W = DATA_WIDTH;

  logic         eb_p0;
  logic         same_p0;
  logic [W-1:0] y_p0;
  logic [W-1:0] na_p0;
  logic [W-1:0] s_main_p0;
  logic [W-1:0] s_rev_p0;
  logic         co_main_p0;
  logic         co_rev_p0;
  logic [W:0]   res_p0;
  logic         res_sign_p0;

  logic [W:0]   out_p1;
  logic         sign_p1;
  logic         vld_p1;

  // Stage p0: main adder does a+b or a-b; its carry-out is the a>=b flag when subtracting.
  assign eb_p0   = sign_b ^ (symbol == OP_SUB);
  assign same_p0 = (sign_a == eb_p0);
  assign y_p0    = same_p0 ? b : ~b;
  assign na_p0   = ~a;

`ifdef BIG_ALU_CLA_EN
  big_alu_cla_adder #(.WIDTH(W)) u_main_add (
    .x    (a),
    .y    (y_p0),
    .cin  (~same_p0),
    .sum  (s_main_p0),
    .cout (co_main_p0)
  );

  big_alu_cla_adder #(.WIDTH(W)) u_rev_sub (
    .x    (b),
    .y    (na_p0),
    .cin  (1'b1),
    .sum  (s_rev_p0),
    .cout (co_rev_p0)
  );
`else
  assign {co_main_p0, s_main_p0} = {1'b0, a} + {1'b0, y_p0} + {{W{1'b0}}, ~same_p0};
  assign {co_rev_p0, s_rev_p0}   = {1'b0, b} + {1'b0, na_p0} + {{W{1'b0}}, 1'b1};
`endif

  // a>=b and b>=a together mean equal magnitudes: force positive zero.
  always_comb begin
    res_p0      = {1'b0, s_main_p0};
    res_sign_p0 = sign_a;
    if (same_p0) begin
      res_p0 = {co_main_p0, s_main_p0};
    end else if (co_main_p0 && co_rev_p0) begin
      res_p0      = '0;
      res_sign_p0 = 1'b0;
    end else if (!co_main_p0) begin
      res_p0      = {1'b0, s_rev_p0};
      res_sign_p0 = eb_p0;
    end
  end

  // Stage p1: output register, holds last result while in_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p1  <= '0;
      sign_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1  <= res_p0;
        sign_p1 <= res_sign_p0;
      end
    end
  end

  assign out       = out_p1;
  assign sign_out  = sign_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_big_alu.sv
// Testbench for big_alu (sign-magnitude add/subtract, one-cycle latency).
module tb_big_alu;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sign_a;
  logic         sign_b;
  logic         symbol;
  logic [W:0]   out;
  logic         sign_out;
  logic         out_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  big_alu #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .symbol    (symbol),
    .out       (out),
    .sign_out  (sign_out),
    .out_valid (out_valid)
  );

  // Signed-integer view of the operation; both-zero same-sign keeps sign_a.
  function automatic void ref_model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                    input logic sa, input logic sb, input logic sym,
                                    output logic [W:0] m, output logic s);
    longint va, vb, r;
    logic   ebit;
    ebit = sb ^ sym;
    va   = sa   ? -longint'(ma) : longint'(ma);
    vb   = ebit ? -longint'(mb) : longint'(mb);
    r    = va + vb;
    m    = (W+1)'(r < 0 ? -r : r);
    if (r == 0) s = (sa == ebit) ? sa : 1'b0;
    else        s = (r < 0);
  endfunction

  function automatic logic [W-1:0] rnd_mag();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 255));
      1:       return {W{1'b1}} - W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic sa, input logic sb, input logic sym);
    in_valid = v;
    a        = ma;
    b        = mb;
    sign_a   = sa;
    sign_b   = sb;
    symbol   = sym;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 24'd1234, 24'd99, 1'b1, 1'b0, 1'b0);
    step();
    step();
    n_cmp++;
    if ({out, sign_out, out_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_state: out=%0d sign=%0b vld=%0b required 0/0/0", out, sign_out, out_valid);
    end
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out !== '0) begin
      n_err++;
      $display("FAIL reset_release_idle: out=%0d vld=%0b required 0/0", out, out_valid);
    end
  endtask

  typedef struct {
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic         sa, sb, sym;
    logic [W:0]   em;
    logic         es;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{24'd100,      24'd215,      1'b0, 1'b0, 1'b0, 25'd315,      1'b0});
    v.push_back('{24'd16777210, 24'd20,       1'b0, 1'b0, 1'b0, 25'd16777230, 1'b0});
    v.push_back('{24'd85,       24'd215,      1'b0, 1'b1, 1'b0, 25'd130,      1'b1});
    v.push_back('{24'd126,      24'd215,      1'b1, 1'b1, 1'b1, 25'd89,       1'b0});
    v.push_back('{24'd100,      24'd16777210, 1'b0, 1'b1, 1'b1, 25'd16777310, 1'b0});
    v.push_back('{24'd100,      24'd16777210, 1'b1, 1'b1, 1'b0, 25'd16777310, 1'b1});
    v.push_back('{24'd50,       24'd50,       1'b1, 1'b0, 1'b0, 25'd0,        1'b0});
    v.push_back('{24'd50,       24'd50,       1'b0, 1'b0, 1'b1, 25'd0,        1'b0});
    v.push_back('{24'hFFFFFF,   24'hFFFFFF,   1'b1, 1'b1, 1'b0, 25'h1FFFFFE,  1'b1});
    v.push_back('{24'd0,        24'hFFFFFF,   1'b0, 1'b0, 1'b1, 25'hFFFFFF,   1'b1});
    foreach (v[i]) begin
      drive(1'b1, v[i].ma, v[i].mb, v[i].sa, v[i].sb, v[i].sym);
      step();
      drive(1'b0, rnd_mag(), rnd_mag(), 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out !== v[i].em || sign_out !== v[i].es) begin
        n_err++;
        $display("FAIL directed_%0d: out=%0d sign=%0b vld=%0b required %0d/%0b/1",
                 i, out, sign_out, out_valid, v[i].em, v[i].es);
      end
    end
  endtask

  task automatic test_hold();
    logic [W:0] held_m;
    logic       held_s;
    logic [W-1:0] ma, mb;
    logic         sa, sb, sym;
    ma = rnd_mag(); mb = rnd_mag();
    sa = 1'($urandom); sb = 1'($urandom); sym = 1'($urandom);
    ref_model(ma, mb, sa, sb, sym, held_m, held_s);
    drive(1'b1, ma, mb, sa, sb, sym);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rnd_mag(), rnd_mag(), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out !== held_m || sign_out !== held_s) begin
        n_err++;
        $display("FAIL hold_%0d: out=%0d sign=%0b vld=%0b required %0d/%0b/0",
                 i, out, sign_out, out_valid, held_m, held_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0]   em;
    logic         es;
    logic [W-1:0] ma, mb;
    logic         sa, sb, sym;
    for (int i = 0; i < 300; i++) begin
      ma = rnd_mag();
      mb = ($urandom_range(0, 4) == 0) ? ma : rnd_mag();
      sa = 1'($urandom); sb = 1'($urandom); sym = 1'($urandom);
      ref_model(ma, mb, sa, sb, sym, em, es);
      drive(1'b1, ma, mb, sa, sb, sym);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== em || sign_out !== es) begin
        n_err++;
        $display("FAIL b2b_%0d: a=%0d b=%0d sa=%0b sb=%0b op=%0b out=%0d sign=%0b vld=%0b required %0d/%0b/1",
                 i, ma, mb, sa, sb, sym, out, sign_out, out_valid, em, es);
      end
    end
  endtask

  task automatic test_gaps();
    logic [W:0]   em, hm;
    logic         es, hs, v;
    logic [W-1:0] ma, mb;
    logic         sa, sb, sym;
    hm = out;
    hs = sign_out;
    for (int i = 0; i < 200; i++) begin
      v  = 1'($urandom);
      ma = rnd_mag();
      mb = ($urandom_range(0, 4) == 0) ? ma : rnd_mag();
      sa = 1'($urandom); sb = 1'($urandom); sym = 1'($urandom);
      ref_model(ma, mb, sa, sb, sym, em, es);
      if (v) begin
        hm = em;
        hs = es;
      end
      drive(v, ma, mb, sa, sb, sym);
      step();
      n_cmp++;
      if (out_valid !== v || out !== hm || sign_out !== hs) begin
        n_err++;
        $display("FAIL gaps_%0d: out=%0d sign=%0b vld=%0b required %0d/%0b/%0b",
                 i, out, sign_out, out_valid, hm, hs, v);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [W:0] em;
    logic       es;
    drive(1'b1, 24'd500, 24'd7, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b1, 24'd900, 24'd1, 1'b1, 1'b0, 1'b1);
    step();
    n_cmp++;
    if ({out, sign_out, out_valid} !== '0) begin
      n_err++;
      $display("FAIL midreset_clear: out=%0d sign=%0b vld=%0b required 0/0/0", out, sign_out, out_valid);
    end
    rst_n = 1'b1;
    drive(1'b0, 24'd900, 24'd1, 1'b1, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out !== '0 || sign_out !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_idle: out=%0d sign=%0b vld=%0b required 0/0/0", out, sign_out, out_valid);
    end
    ref_model(24'd40, 24'd300, 1'b0, 1'b0, 1'b1, em, es);
    drive(1'b1, 24'd40, 24'd300, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== em || sign_out !== es) begin
      n_err++;
      $display("FAIL midreset_first: out=%0d sign=%0b vld=%0b required %0d/%0b/1",
               out, sign_out, out_valid, em, es);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_gaps();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/big_alu.md
BIG_ALU -- requirements
Module: big_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 24, mantissa magnitude width W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operands valid this cycle.
REQ-005 a  input  W  magnitude of operand A, unsigned.
REQ-006 b  input  W  magnitude of operand B, unsigned.
REQ-007 sign_a  input  1  sign of A (1 = negative).
REQ-008 sign_b  input  1  sign of B (1 = negative).
REQ-009 symbol  input  1  operation (0 = A+B, 1 = A-B).
REQ-010 out  output  W+1  result magnitude, bit W is the carry from magnitude addition.
REQ-011 sign_out  output  1  result sign.
REQ-012 out_valid  output  1  out/sign_out hold a new result.

Function
REQ-013 Effective B sign eb = sign_b XOR symbol.
REQ-014 sign_a == eb: out = a + b zero-extended to W+1 bits, no overflow loss; sign_out = sign_a.
REQ-015 sign_a != eb and a > b: out = a - b; sign_out = sign_a.
REQ-016 sign_a != eb and b > a: out = b - a; sign_out = eb.
REQ-017 sign_a != eb and a == b: out = 0, sign_out = 0 (positive zero only; negative zero never produced).
REQ-018 Magnitude compare via borrow of a - b computed in the same adder; no separate comparator path required.
REQ-019 Latency exactly 1 cycle: operands sampled on edge where in_valid=1; result and out_valid=1 visible after that edge.
REQ-020 in_valid=0 on an edge: out_valid goes 0; out/sign_out hold previous values.
REQ-021 Back-to-back in_valid accepted every cycle; no backpressure, no stall.

Reset
REQ-022 rst_n=0 on an edge: out=0, sign_out=0, out_valid=0; overrides in_valid on the same edge.
REQ-023 Reset asserted mid-stream discards the operand sampled that cycle; first valid result after release appears one cycle after first in_valid.

Configuration
REQ-024 Macro BIG_ALU_CLA_EN defined: magnitude add/subtract built from carry-lookahead sub-module (4-bit groups, group generate/propagate, lookahead across groups).
REQ-025 BIG_ALU_CLA_EN undefined: behavioural ripple add/subtract; results bit-identical to CLA build for all inputs.

Structure
REQ-026 Package big_alu_pkg holds DATA_WIDTH default (24), CLA group size constant (4), and op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-027 One sub-module big_alu_cla_adder: W-bit operands, carry-in (1 for two's-complement subtract), W-bit sum, carry-out; instantiated only under BIG_ALU_CLA_EN.
REQ-028 Subtraction b - a reuses the adder with swapped operands or negates a - b; either permitted, single output register stage.

Verification
REQ-029 a=100, b=215, sign_a=0, sign_b=0, symbol=0 -> out=315, sign_out=0, one cycle later with out_valid=1.
REQ-030 a=16777210, b=20, all signs 0, symbol=0 -> out=16777230 (bit 24 set), sign_out=0.
REQ-031 a=85, b=215, sign_a=0, sign_b=1, symbol=0 -> out=130, sign_out=1; a=126, b=215, sign_a=1, sign_b=1, symbol=1 -> out=89, sign_out=0.
REQ-032 a=100, b=16777210, sign_a=0, sign_b=1, symbol=1 -> out=16777310, sign_out=0; same with sign_a=1, sign_b=1, symbol=0 -> out=16777310, sign_out=1.
REQ-033 a=b=50, sign_a=1, sign_b=0, symbol=0 -> out=0, sign_out=0.
REQ-034 rst_n=0 on an edge with in_valid=1 -> out=0, sign_out=0, out_valid=0; run all scenarios with and without BIG_ALU_CLA_EN, outputs identical.
